// File: rtl/nav_pkg.sv
// rtl/nav_pkg.sv - shared types and heading constants for the gyro heading sequencer
package nav_pkg;

    typedef enum logic [1:0] {
        CMD_FWD   = 2'b00,
        CMD_LEFT  = 2'b01,
        CMD_RIGHT = 2'b10,
        CMD_REV   = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        CAL_REQ  = 3'd0,
        CAL_WAIT = 3'd1,
        READY    = 3'd2,
        TURN     = 3'd3,
        FWD      = 3'd4,
        ERR      = 3'd5
    } seq_state_t;

    localparam logic [11:0] HDG_QTR  = 12'h400;
    localparam logic [11:0] HDG_HALF = 12'h800;

    // Heading arithmetic wraps modulo 4096 on purpose: a full circle is 12'h000..12'hFFF.
    function automatic logic [11:0] next_hdng(input logic [11:0] cur, input cmd_t c);
        logic [11:0] nxt;
        case (c)
            CMD_LEFT:  nxt = cur + HDG_QTR;
            CMD_RIGHT: nxt = cur - HDG_QTR;
            CMD_REV:   nxt = cur + HDG_HALF;
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/heading_seq_if.sv
// rtl/heading_seq_if.sv - command, integrator and drive signals between sequencer and its neighbours
interface heading_seq_if;
    logic        recal;
    logic        cmd_vld;
    logic [1:0]  cmd;
    logic        cmd_rdy;
    logic        fwd_done;
    logic        strt_cal;
    logic        cal_done;
    logic        rdy;
    logic [11:0] heading;
    logic        moving;
    logic        en_fusion;
    logic        fwd;
    logic [11:0] dsrd_hdng;
    logic        turn_done;
    logic        err;

    modport master (
        output recal, cmd_vld, cmd, fwd_done, cal_done, rdy, heading,
        input  cmd_rdy, strt_cal, moving, en_fusion, fwd, dsrd_hdng, turn_done, err
    );

    modport slave (
        input  recal, cmd_vld, cmd, fwd_done, cal_done, rdy, heading,
        output cmd_rdy, strt_cal, moving, en_fusion, fwd, dsrd_hdng, turn_done, err
    );
endinterface

// File: rtl/hdng_settle_chk.sv
// rtl/hdng_settle_chk.sv - wrapped heading error, tolerance test, settle and timeout counting
module hdng_settle_chk #(
    parameter logic [11:0] HDG_TOL      = 12'h02C,
    parameter int          SETTLE_SMPLS = 4,
    parameter int          TMO_SMPLS    = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        rdy,
    input  logic [11:0] dsrd_hdng,
    input  logic [11:0] heading,
    output logic        settled,
    output logic        timeout
);

    localparam int SW = $clog2(SETTLE_SMPLS + 1);
    localparam int TW = $clog2(TMO_SMPLS + 1);
    localparam logic [SW-1:0] SETTLE_TERM = SW'(SETTLE_SMPLS);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_SMPLS - 1);
    localparam logic [TW-1:0] TMO_TERM    = TW'(TMO_SMPLS);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TMO_SMPLS - 1);

    logic [SW-1:0] r_settle_cnt;
    logic [TW-1:0] r_tmo_cnt;
    logic [11:0]   w_err_h;
    logic [12:0]   w_err_ext;
    logic [12:0]   w_mag;
    logic          w_in_tol;

    // Magnitude is taken at 13 bits so an error of -2048 yields +2048 instead of overflowing.
    assign w_err_h   = dsrd_hdng - heading;
    assign w_err_ext = {w_err_h[11], w_err_h};
    assign w_mag     = w_err_ext[12] ? (13'd0 - w_err_ext) : w_err_ext;
    assign w_in_tol  = (w_mag <= {1'b0, HDG_TOL});

    assign settled = !clr && rdy && w_in_tol && (r_settle_cnt >= SETTLE_LAST);
    assign timeout = !clr && rdy && (r_tmo_cnt >= TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
            r_tmo_cnt    <= '0;
        end else if (clr) begin
            r_settle_cnt <= '0;
            r_tmo_cnt    <= '0;
        end else if (rdy) begin
            if (!w_in_tol)
                r_settle_cnt <= '0;
            else if (r_settle_cnt != SETTLE_TERM)
                r_settle_cnt <= r_settle_cnt + 1'b1;
            if (r_tmo_cnt != TMO_TERM)
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/heading_seq.sv
// rtl/heading_seq.sv - calibration, move-command and turn-settle sequencer for the gyro integrator
module heading_seq
    import nav_pkg::*;
#(
    parameter int          FAST_SIM     = 1,
    parameter logic [11:0] HDG_TOL      = 12'h02C,
    parameter int          SETTLE_SMPLS = 4,
    parameter int          TMO_SMPLS    = (FAST_SIM != 0) ? 256 : 2048,
    parameter int          FUS_DLY      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    heading_seq_if.slave  bus
);

    localparam int FW = $clog2(FUS_DLY + 1);
    localparam logic [FW-1:0] FUS_TERM = FW'(FUS_DLY);

    seq_state_t  r_state;
    seq_state_t  w_next;
    logic [11:0] r_dsrd_hdng;
    logic        r_strt_cal;
    logic        r_turn_done;
    logic [FW-1:0] r_fus_cnt;

    cmd_t w_cmd;
    logic w_accept;
    logic w_settled;
    logic w_timeout;
    logic w_clr;
    logic w_cmd_rdy;
    logic w_moving;
    logic w_fwd;
    logic w_en_fusion;
    logic w_err;

    assign w_cmd    = cmd_t'(bus.cmd);
    assign w_accept = (r_state == READY) && bus.cmd_vld && !bus.recal;

    hdng_settle_chk #(
        .HDG_TOL      (HDG_TOL),
        .SETTLE_SMPLS (SETTLE_SMPLS),
        .TMO_SMPLS    (TMO_SMPLS)
    ) u_settle_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_clr),
        .rdy       (bus.rdy),
        .dsrd_hdng (r_dsrd_hdng),
        .heading   (bus.heading),
        .settled   (w_settled),
        .timeout   (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= CAL_REQ;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            CAL_REQ:  w_next = CAL_WAIT;
            CAL_WAIT: if (bus.cal_done) w_next = READY;
            READY: begin
                if (bus.recal)
                    w_next = CAL_REQ;
                else if (bus.cmd_vld)
                    w_next = (w_cmd == CMD_FWD) ? FWD : TURN;
            end
            // Settle wins over timeout when both land on the same sample.
            TURN: begin
                if (w_settled)
                    w_next = READY;
                else if (w_timeout)
                    w_next = ERR;
            end
            FWD:      if (bus.fwd_done) w_next = READY;
            ERR:      if (bus.recal) w_next = CAL_REQ;
            default:  w_next = CAL_REQ;
        endcase
    end

    always_comb begin
        w_cmd_rdy   = 1'b0;
        w_moving    = 1'b0;
        w_fwd       = 1'b0;
        w_en_fusion = 1'b0;
        w_err       = 1'b0;
        w_clr       = 1'b1;
        case (r_state)
            READY: w_cmd_rdy = 1'b1;
            TURN: begin
                w_moving = 1'b1;
                w_clr    = 1'b0;
            end
            FWD: begin
                w_moving    = 1'b1;
                w_fwd       = 1'b1;
                w_en_fusion = (r_fus_cnt == FUS_TERM);
            end
            ERR:     w_err = 1'b1;
            default: ;
        endcase
    end

    // Desired heading restarts at 0 because the integrator zeroes its heading on calibration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dsrd_hdng <= '0;
            r_strt_cal  <= 1'b0;
            r_turn_done <= 1'b0;
            r_fus_cnt   <= '0;
        end else begin
            r_strt_cal  <= (r_state == CAL_REQ);
            r_turn_done <= (r_state == TURN) && w_settled;
            if (r_state == CAL_REQ)
                r_dsrd_hdng <= '0;
            else if (w_accept)
                r_dsrd_hdng <= next_hdng(r_dsrd_hdng, w_cmd);
            if (r_state != FWD)
                r_fus_cnt <= '0;
            else if (bus.rdy && (r_fus_cnt != FUS_TERM))
                r_fus_cnt <= r_fus_cnt + 1'b1;
        end
    end

    assign bus.cmd_rdy   = w_cmd_rdy;
    assign bus.strt_cal  = r_strt_cal;
    assign bus.moving    = w_moving;
    assign bus.en_fusion = w_en_fusion;
    assign bus.fwd       = w_fwd;
    assign bus.dsrd_hdng = r_dsrd_hdng;
    assign bus.turn_done = r_turn_done;
    assign bus.err       = w_err;

endmodule

// File: tb/tb_heading_seq.sv
// tb/tb_heading_seq.sv - directed self-checking bench for heading_seq
module tb_heading_seq;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    heading_seq_if bus();

    heading_seq #(.FAST_SIM(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [11:0] h);
        bus.rdy     = 1'b1;
        bus.heading = h;
        tick();
        bus.rdy     = 1'b0;
    endtask

    task automatic issue(input logic [1:0] c);
        bus.cmd     = c;
        bus.cmd_vld = 1'b1;
        tick();
        bus.cmd_vld = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if ({bus.strt_cal, bus.cmd_rdy, bus.moving, bus.fwd, bus.en_fusion, bus.turn_done, bus.err} !== 7'b0) begin n_bad++; $display("FAIL reset_outs: got %b want 0000000", {bus.strt_cal, bus.cmd_rdy, bus.moving, bus.fwd, bus.en_fusion, bus.turn_done, bus.err}); end
        n_cmp++; if (bus.dsrd_hdng !== 12'h000) begin n_bad++; $display("FAIL reset_dsrd: got %h want 000", bus.dsrd_hdng); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.strt_cal !== 1'b1) begin n_bad++; $display("FAIL strt_cal_pulse: got %b want 1", bus.strt_cal); end
        tick();
        n_cmp++; if (bus.strt_cal !== 1'b0) begin n_bad++; $display("FAIL strt_cal_one_cycle: got %b want 0", bus.strt_cal); end
        repeat (18) tick();
        n_cmp++; if (bus.cmd_rdy !== 1'b0) begin n_bad++; $display("FAIL cal_wait_rdy: got %b want 0", bus.cmd_rdy); end
        bus.cal_done = 1'b1;
        tick();
        bus.cal_done = 1'b0;
        n_cmp++; if ({bus.cmd_rdy, bus.moving} !== 2'b10) begin n_bad++; $display("FAIL ready_after_cal: got %b want 10", {bus.cmd_rdy, bus.moving}); end
    endtask

    task automatic test_left();
        issue(2'b01);
        n_cmp++; if (bus.dsrd_hdng !== 12'h400) begin n_bad++; $display("FAIL left_dsrd: got %h want 400", bus.dsrd_hdng); end
        n_cmp++; if ({bus.moving, bus.cmd_rdy, bus.fwd, bus.en_fusion} !== 4'b1000) begin n_bad++; $display("FAIL left_quals: got %b want 1000", {bus.moving, bus.cmd_rdy, bus.fwd, bus.en_fusion}); end
        feed(12'h300);
        for (int i = 0; i < 3; i++) feed(12'h3E0);
        n_cmp++; if (bus.turn_done !== 1'b0) begin n_bad++; $display("FAIL left_early_done: got %b want 0", bus.turn_done); end
        feed(12'h3E0);
        n_cmp++; if ({bus.turn_done, bus.moving, bus.cmd_rdy} !== 3'b101) begin n_bad++; $display("FAIL left_done: got %b want 101", {bus.turn_done, bus.moving, bus.cmd_rdy}); end
        tick();
        n_cmp++; if (bus.turn_done !== 1'b0) begin n_bad++; $display("FAIL left_done_pulse: got %b want 0", bus.turn_done); end
    endtask

    task automatic test_wrap();
        issue(2'b10);
        n_cmp++; if (bus.dsrd_hdng !== 12'h000) begin n_bad++; $display("FAIL right_to_zero: got %h want 000", bus.dsrd_hdng); end
        for (int i = 0; i < 4; i++) feed(12'h010);
        n_cmp++; if (bus.turn_done !== 1'b1) begin n_bad++; $display("FAIL right_neg_err_done: got %b want 1", bus.turn_done); end
        issue(2'b10);
        n_cmp++; if (bus.dsrd_hdng !== 12'hC00) begin n_bad++; $display("FAIL right_wrap_dsrd: got %h want c00", bus.dsrd_hdng); end
        for (int i = 0; i < 3; i++) feed(12'hC10);
        n_cmp++; if (bus.turn_done !== 1'b0) begin n_bad++; $display("FAIL wrap_early_done: got %b want 0", bus.turn_done); end
        feed(12'hC10);
        n_cmp++; if (bus.turn_done !== 1'b1) begin n_bad++; $display("FAIL wrap_done: got %b want 1", bus.turn_done); end
    endtask

    task automatic test_settle_reset();
        issue(2'b01);
        n_cmp++; if (bus.dsrd_hdng !== 12'h000) begin n_bad++; $display("FAIL left_wrap_zero: got %h want 000", bus.dsrd_hdng); end
        feed(12'h02C);
        feed(12'hFD3);
        for (int i = 0; i < 3; i++) feed(12'hFD4);
        n_cmp++; if (bus.turn_done !== 1'b0) begin n_bad++; $display("FAIL settle_reset_5th: got %b want 0", bus.turn_done); end
        feed(12'hFD4);
        n_cmp++; if (bus.turn_done !== 1'b1) begin n_bad++; $display("FAIL settle_reset_6th: got %b want 1", bus.turn_done); end
    endtask

    task automatic test_rev();
        issue(2'b11);
        n_cmp++; if (bus.dsrd_hdng !== 12'h800) begin n_bad++; $display("FAIL rev_dsrd: got %h want 800", bus.dsrd_hdng); end
        feed(12'h000);
        for (int i = 0; i < 3; i++) feed(12'h7F0);
        n_cmp++; if (bus.turn_done !== 1'b0) begin n_bad++; $display("FAIL rev_min_err_out: got %b want 0", bus.turn_done); end
        feed(12'h7F0);
        n_cmp++; if (bus.turn_done !== 1'b1) begin n_bad++; $display("FAIL rev_done: got %b want 1", bus.turn_done); end
        issue(2'b11);
        n_cmp++; if (bus.dsrd_hdng !== 12'h000) begin n_bad++; $display("FAIL rev_wrap_dsrd: got %h want 000", bus.dsrd_hdng); end
        for (int i = 0; i < 4; i++) feed(12'h000);
        n_cmp++; if (bus.turn_done !== 1'b1) begin n_bad++; $display("FAIL rev_wrap_done: got %b want 1", bus.turn_done); end
    endtask

    task automatic test_timeout();
        issue(2'b01);
        for (int i = 0; i < 255; i++) feed(12'h000);
        n_cmp++; if ({bus.err, bus.moving} !== 2'b01) begin n_bad++; $display("FAIL tmo_255: got %b want 01", {bus.err, bus.moving}); end
        feed(12'h000);
        n_cmp++; if ({bus.err, bus.moving, bus.cmd_rdy, bus.turn_done} !== 4'b1000) begin n_bad++; $display("FAIL tmo_256: got %b want 1000", {bus.err, bus.moving, bus.cmd_rdy, bus.turn_done}); end
        issue(2'b10);
        n_cmp++; if ({bus.err, bus.dsrd_hdng} !== {1'b1, 12'h400}) begin n_bad++; $display("FAIL err_ignores_cmd: got %b/%h want 1/400", bus.err, bus.dsrd_hdng); end
        bus.recal = 1'b1;
        tick();
        bus.recal = 1'b0;
        n_cmp++; if ({bus.err, bus.strt_cal} !== 2'b00) begin n_bad++; $display("FAIL recal_clears_err: got %b want 00", {bus.err, bus.strt_cal}); end
        tick();
        n_cmp++; if ({bus.strt_cal, bus.dsrd_hdng} !== {1'b1, 12'h000}) begin n_bad++; $display("FAIL recal_strt_cal: got %b/%h want 1/000", bus.strt_cal, bus.dsrd_hdng); end
        bus.recal = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if ({bus.strt_cal, bus.cmd_rdy} !== 2'b00) begin n_bad++; $display("FAIL cal_wait_ignores_recal: got %b want 00", {bus.strt_cal, bus.cmd_rdy}); end
        end
        bus.recal    = 1'b0;
        bus.cal_done = 1'b1;
        tick();
        bus.cal_done = 1'b0;
        n_cmp++; if (bus.cmd_rdy !== 1'b1) begin n_bad++; $display("FAIL recal_ready: got %b want 1", bus.cmd_rdy); end
    endtask

    task automatic test_fwd();
        issue(2'b00);
        n_cmp++; if ({bus.fwd, bus.moving, bus.en_fusion, bus.cmd_rdy, bus.dsrd_hdng} !== {4'b1100, 12'h000}) begin n_bad++; $display("FAIL fwd_entry: got %b/%h want 1100/000", {bus.fwd, bus.moving, bus.en_fusion, bus.cmd_rdy}, bus.dsrd_hdng); end
        for (int i = 0; i < 7; i++) feed(12'h123);
        n_cmp++; if (bus.en_fusion !== 1'b0) begin n_bad++; $display("FAIL fus_7th: got %b want 0", bus.en_fusion); end
        feed(12'h123);
        n_cmp++; if (bus.en_fusion !== 1'b1) begin n_bad++; $display("FAIL fus_8th: got %b want 1", bus.en_fusion); end
        issue(2'b01);
        n_cmp++; if ({bus.fwd, bus.en_fusion, bus.dsrd_hdng} !== {2'b11, 12'h000}) begin n_bad++; $display("FAIL fwd_ignores_cmd: got %b/%h want 11/000", {bus.fwd, bus.en_fusion}, bus.dsrd_hdng); end
        bus.fwd_done = 1'b1;
        tick();
        bus.fwd_done = 1'b0;
        n_cmp++; if ({bus.fwd, bus.en_fusion, bus.moving, bus.cmd_rdy} !== 4'b0001) begin n_bad++; $display("FAIL fwd_done_exit: got %b want 0001", {bus.fwd, bus.en_fusion, bus.moving, bus.cmd_rdy}); end
    endtask

    task automatic test_recal_priority();
        bus.cmd     = 2'b01;
        bus.cmd_vld = 1'b1;
        bus.recal   = 1'b1;
        tick();
        bus.cmd_vld = 1'b0;
        bus.recal   = 1'b0;
        n_cmp++; if ({bus.cmd_rdy, bus.moving, bus.dsrd_hdng} !== {2'b00, 12'h000}) begin n_bad++; $display("FAIL recal_wins: got %b/%h want 00/000", {bus.cmd_rdy, bus.moving}, bus.dsrd_hdng); end
        tick();
        n_cmp++; if (bus.strt_cal !== 1'b1) begin n_bad++; $display("FAIL recal_wins_cal: got %b want 1", bus.strt_cal); end
        bus.cal_done = 1'b1;
        tick();
        bus.cal_done = 1'b0;
    endtask

    task automatic test_reset_mid_turn();
        issue(2'b01);
        feed(12'h300);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.moving, bus.cmd_rdy, bus.dsrd_hdng} !== {2'b00, 12'h000}) begin n_bad++; $display("FAIL mid_turn_reset: got %b/%h want 00/000", {bus.moving, bus.cmd_rdy}, bus.dsrd_hdng); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.strt_cal !== 1'b1) begin n_bad++; $display("FAIL recal_after_reset: got %b want 1", bus.strt_cal); end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        bus.recal    = 1'b0;
        bus.cmd_vld  = 1'b0;
        bus.cmd      = 2'b00;
        bus.fwd_done = 1'b0;
        bus.cal_done = 1'b0;
        bus.rdy      = 1'b0;
        bus.heading  = 12'h000;
        test_reset();
        test_left();
        test_wrap();
        test_settle_reset();
        test_rev();
        test_timeout();
        test_fwd();
        test_recal_priority();
        test_reset_mid_turn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/heading_seq.md
Name: heading_seq

Overview:
- Sequencer for the gyro inertial integrator.
- Issues the calibration request after reset, or when recalibration is asked for, then waits for cal_done.
- Accepts move commands from the maze solver (forward, left, right, reverse) and maintains the desired heading.
- Drives the integrator's moving and en_fusion qualifiers, and reports turn completion or turn timeout.

Parameters:
FAST_SIM, 1, shortens TMO_SMPLS for simulation.
HDG_TOL, 12'h02C, allowed |heading error| for a turn to count as settled.
SETTLE_SMPLS, 4, consecutive in-tolerance rdy samples required to finish a turn.
TMO_SMPLS, 2048 (256 when FAST_SIM=1), maximum rdy samples per turn before error.
FUS_DLY, 8, rdy samples into a forward move before en_fusion asserts.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
recal  in  1  request recalibration; honoured only in READY or ERR
cmd_vld  in  1  move command valid
cmd  in  2  00=FWD, 01=LEFT, 10=RIGHT, 11=REV
cmd_rdy  out  1  sequencer can accept a command
fwd_done  in  1  pulse from the drive logic: forward segment finished
strt_cal  out  1  one-cycle pulse to the integrator
cal_done  in  1  calibration complete, from the integrator
rdy  in  1  integrator has a new heading sample
heading  in  12  signed integrator heading
moving  out  1  qualifies integration
en_fusion  out  1  enables IR fusion in the integrator
fwd  out  1  drive straight ahead
dsrd_hdng  out  12  signed desired heading
turn_done  out  1  one-cycle pulse when a turn settles
err  out  1  sticky turn-timeout flag

Behaviour:
- Reset values: all outputs 0, dsrd_hdng=0, state=CAL_REQ.
- Reset may assert at any cycle, including mid-turn or mid-calibration. It immediately returns the block to these values, and a fresh calibration follows.
- States: CAL_REQ, CAL_WAIT, READY, TURN, FWD, ERR.
- CAL_REQ:
  - strt_cal is registered and high for exactly one cycle.
  - Next state is CAL_WAIT unconditionally.
  - dsrd_hdng is cleared to 0, because the integrator zeroes heading at calibration.
- CAL_WAIT:
  - moving=0; wait for cal_done.
  - cal_done -> READY.
  - recal is ignored here.
- READY:
  - cmd_rdy=1; moving=0.
  - A command is accepted on a cycle where cmd_vld and cmd_rdy are both 1. cmd_rdy drops on the next edge.
  - If recal and cmd_vld are high in the same cycle, recal wins and the command is not accepted.
  - recal -> CAL_REQ.
- Command acceptance:
  - FWD: dsrd_hdng unchanged -> FWD.
  - LEFT: dsrd_hdng += 12'h400 -> TURN.
  - RIGHT: dsrd_hdng -= 12'h400 -> TURN.
  - REV: dsrd_hdng += 12'h800 -> TURN.
  - All heading arithmetic is 12-bit modulo 4096. Wrap-around is intentional: 12'h400+12'h400 = 12'h800 = -2048.
  - dsrd_hdng updates on the same edge that enters TURN or FWD.
- TURN:
  - moving=1, fwd=0, en_fusion=0.
  - On each rdy: err_h = dsrd_hdng - heading, a 12-bit wrapped signed result.
  - In tolerance when |err_h| <= HDG_TOL. Magnitude is computed at 13 bits, so -2048 gives 2048 with no overflow.
  - The settle counter increments on an in-tolerance rdy and clears on an out-of-tolerance rdy.
  - When it reaches SETTLE_SMPLS: turn_done pulses for one cycle and the state -> READY.
  - The timeout counter counts rdy samples, resetting on entry to TURN.
  - When it reaches TMO_SMPLS with no settle: err=1, state -> ERR.
  - Settle has priority if both occur on the same rdy.
- FWD:
  - moving=1, fwd=1.
  - en_fusion asserts after FUS_DLY rdy samples in FWD, then stays high until exit.
  - fwd_done -> READY; fwd and en_fusion drop on that edge.
  - cmd_vld is ignored.
- ERR:
  - moving=0, cmd_rdy=0, err held.
  - Only recal exits: -> CAL_REQ, clearing err.
- Counters never wrap; they saturate at their terminal value.

Decomposition:
- nav_pkg holds:
  - cmd_t enum {CMD_FWD, CMD_LEFT, CMD_RIGHT, CMD_REV}
  - seq_state_t
  - constants HDG_QTR=12'h400 and HDG_HALF=12'h800
- Sub-module hdng_settle_chk: computes wrapped error, magnitude, tolerance compare, settle counter and timeout counter. Inputs are clr, rdy, dsrd_hdng and heading; outputs are settled and timeout.

Test Plan:
- Reset release: strt_cal pulses 1 cycle at the first edge. Raise cal_done 20 cycles later -> READY and cmd_rdy=1.
- LEFT from 0: dsrd_hdng=12'h400. Drive heading 12'h300 then 12'h3E0 ×4 with rdy -> turn_done after the 4th in-tolerance rdy; moving falls.
- Wrap: RIGHT from 0 gives dsrd_hdng=12'hC00. Feed heading 12'hC10 -> err_h=-16, in tolerance; settles after 4 rdy.
- Settle reset: feed heading in/out/in/in/in/in -> turn_done only after the 6th rdy.
- Timeout: hold heading 12'h000 during LEFT -> err=1 after 256 rdy (FAST_SIM). recal -> strt_cal pulse, err clears.
- FWD: en_fusion rises after the 8th rdy. fwd_done -> fwd=0 and en_fusion=0 next cycle. cmd_vld together with recal in READY -> recal wins.
